// File: rtl/touch_pkg.sv
// Shared types and widths for the touch event filter: FSM state encoding,
// coordinate and gesture widths, and a saturating byte increment.
package touch_pkg;

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned GW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPressPend,
    StPressed,
    StReleasePend
  } touch_state_e;

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/touch_event_filter_if.sv
// Bundle between the touch event filter and the touch I2C controller side.
// The filter is the master (it issues read requests and publishes events).
interface touch_event_filter_if;
  import touch_pkg::*;

  logic          oTRIG;
  logic          iREADY;
  logic [XW-1:0] iX1;
  logic [YW-1:0] iY1;
  logic [1:0]    iTOUCH_COUNT;
  logic [GW-1:0] iGESTURE;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic          oPRESS;
  logic          oTAP;
  logic          oLONG;
  logic          oRELEASE;
  logic [GW-1:0] oGESTURE;
  logic          oGEST_STB;
  logic [7:0]    oMISS;

  modport master (
    input  iREADY, iX1, iY1, iTOUCH_COUNT, iGESTURE,
    output oTRIG, oX, oY, oPRESS, oTAP, oLONG, oRELEASE, oGESTURE, oGEST_STB, oMISS
  );

  modport slave (
    output iREADY, iX1, iY1, iTOUCH_COUNT, iGESTURE,
    input  oTRIG, oX, oY, oPRESS, oTAP, oLONG, oRELEASE, oGESTURE, oGEST_STB, oMISS
  );

endinterface

// File: rtl/touch_avg4.sv
// Four-deep coordinate history with a moving average (sum >> 2, truncated).
// load fills every entry with the incoming sample; push shifts it in.
module touch_avg4
  import touch_pkg::*;
(
  input  logic          iCLK,
  input  logic          iRSTN,
  input  logic          load,
  input  logic          push,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  output logic [XW-1:0] x_avg,
  output logic [YW-1:0] y_avg
);

  logic [XW-1:0] hx_q [4];
  logic [YW-1:0] hy_q [4];
  logic [XW+1:0] sum_x;
  logic [YW+1:0] sum_y;

  // History registers: preload on first sample of a press, else shift.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < 4; i++) begin
        hx_q[i] <= '0;
        hy_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < 4; i++) begin
        hx_q[i] <= x_in;
        hy_q[i] <= y_in;
      end
    end else if (push) begin
      for (int i = 3; i > 0; i--) begin
        hx_q[i] <= hx_q[i-1];
        hy_q[i] <= hy_q[i-1];
      end
      hx_q[0] <= x_in;
      hy_q[0] <= y_in;
    end
  end

  // Average of the stored history.
  always_comb begin
    sum_x = 12'(hx_q[0]) + 12'(hx_q[1]) + 12'(hx_q[2]) + 12'(hx_q[3]);
    sum_y = 11'(hy_q[0]) + 11'(hy_q[1]) + 11'(hy_q[2]) + 11'(hy_q[3]);
    x_avg = sum_x[XW+1:2];
    y_avg = sum_y[YW+1:2];
  end

endmodule

// File: rtl/touch_event_filter.sv
// Touch event filter: periodically requests samples from the touch controller,
// debounces the press state and emits tap / long-press / release / gesture
// events. Define TOUCH_AVG_EN to smooth coordinates with a 4-sample average.
module touch_event_filter
  import touch_pkg::*;
#(
  parameter int unsigned POLL_DIV     = 2_500_000,
  parameter int unsigned DEB_CNT      = 3,
  parameter int unsigned HOLD_SAMPLES = 20
) (
  input logic                 iCLK,
  input logic                 iRSTN,
  touch_event_filter_if.master bus
);

  localparam int unsigned CntW  = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [3:0]  DebT  = 4'(DEB_CNT);
  localparam logic [7:0]  HoldT = 8'(HOLD_SAMPLES);

  logic [CntW-1:0] cnt_q;
  logic            wrap;
  logic            busy_q, busy_d;
  logic            trig_q, trig_d;
  logic [7:0]      miss_q, miss_d;

  touch_state_e    state_q, state_d;
  logic [3:0]      deb_q, deb_d, deb_inc;
  logic [7:0]      hold_q, hold_d, hold_inc;
  logic            press_q, press_d;
  logic            tap_q, tap_d;
  logic            long_q, long_d;
  logic            rel_q, rel_d;
  logic            touched;
  logic            upd;

  logic [GW-1:0]   gest_q;
  logic            gstb_q;

  assign wrap    = (cnt_q == CntW'(POLL_DIV - 1));
  assign touched = (bus.iTOUCH_COUNT != 2'd0);

  // Free-running poll divider.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) cnt_q <= '0;
    else        cnt_q <= wrap ? '0 : cnt_q + CntW'(1);
  end

  // Request/busy tracking; a ready coincident with wrap frees the slot first.
  always_comb begin
    busy_d = busy_q;
    trig_d = 1'b0;
    miss_d = miss_q;
    if (wrap) begin
      if (!busy_q || bus.iREADY) begin
        trig_d = 1'b1;
        busy_d = 1'b1;
      end else begin
        miss_d = sat_inc8(miss_q);
      end
    end else if (bus.iREADY) begin
      busy_d = 1'b0;
    end
  end

  // Poll state registers.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      busy_q <= 1'b0;
      trig_q <= 1'b0;
      miss_q <= '0;
    end else begin
      busy_q <= busy_d;
      trig_q <= trig_d;
      miss_q <= miss_d;
    end
  end

  // Press FSM next state and event pulses; only advances on a sample.
  always_comb begin
    state_d  = state_q;
    deb_d    = deb_q;
    hold_d   = hold_q;
    press_d  = press_q;
    tap_d    = 1'b0;
    long_d   = 1'b0;
    rel_d    = 1'b0;
    upd      = 1'b0;
    deb_inc  = deb_q + 4'd1;
    hold_inc = sat_inc8(hold_q);
    if (bus.iREADY) begin
      unique case (state_q)
        StIdle: begin
          if (touched) begin
            upd = 1'b1;
            if (DebT <= 4'd1) begin
              state_d = StPressed;
              press_d = 1'b1;
              hold_d  = '0;
            end else begin
              state_d = StPressPend;
              deb_d   = 4'd1;
            end
          end
        end
        StPressPend: begin
          if (touched) begin
            upd   = 1'b1;
            deb_d = deb_inc;
            if (deb_inc >= DebT) begin
              state_d = StPressed;
              press_d = 1'b1;
              hold_d  = '0;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StPressed: begin
          if (touched) begin
            upd    = 1'b1;
            hold_d = hold_inc;
            // hold only grows within a press, so equality is crossed once
            long_d = (hold_q != HoldT) && (hold_inc == HoldT);
          end else if (DebT <= 4'd1) begin
            state_d = StIdle;
            press_d = 1'b0;
            rel_d   = 1'b1;
            tap_d   = (hold_q < HoldT);
          end else begin
            state_d = StReleasePend;
            deb_d   = 4'd1;
          end
        end
        StReleasePend: begin
          if (touched) begin
            upd     = 1'b1;
            state_d = StPressed;
          end else begin
            deb_d = deb_inc;
            if (deb_inc >= DebT) begin
              state_d = StIdle;
              press_d = 1'b0;
              rel_d   = 1'b1;
              tap_d   = (hold_q < HoldT);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Press FSM registers and event outputs.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q <= StIdle;
      deb_q   <= '0;
      hold_q  <= '0;
      press_q <= 1'b0;
      tap_q   <= 1'b0;
      long_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      tap_q   <= tap_d;
      long_q  <= long_d;
      rel_q   <= rel_d;
    end
  end

  // Gesture latch, independent of the press state.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      gest_q <= '0;
      gstb_q <= 1'b0;
    end else begin
      gstb_q <= bus.iREADY && (bus.iGESTURE != '0);
      if (bus.iREADY && (bus.iGESTURE != '0)) gest_q <= bus.iGESTURE;
    end
  end

`ifdef TOUCH_AVG_EN
  logic          hist_load;
  logic          hist_push;
  logic [XW-1:0] x_avg;
  logic [YW-1:0] y_avg;

  // A touched sample leaving IDLE starts a new press and preloads history.
  assign hist_load = upd && (state_q == StIdle);
  assign hist_push = upd && (state_q != StIdle);

  touch_avg4 u_avg (
    .iCLK  (iCLK),
    .iRSTN (iRSTN),
    .load  (hist_load),
    .push  (hist_push),
    .x_in  (bus.iX1),
    .y_in  (bus.iY1),
    .x_avg (x_avg),
    .y_avg (y_avg)
  );

  assign bus.oX = x_avg;
  assign bus.oY = y_avg;
`else
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Coordinates follow the latest touched sample.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      x_q <= '0;
      y_q <= '0;
    end else if (upd) begin
      x_q <= bus.iX1;
      y_q <= bus.iY1;
    end
  end

  assign bus.oX = x_q;
  assign bus.oY = y_q;
`endif

  assign bus.oTRIG     = trig_q;
  assign bus.oMISS     = miss_q;
  assign bus.oPRESS    = press_q;
  assign bus.oTAP      = tap_q;
  assign bus.oLONG     = long_q;
  assign bus.oRELEASE  = rel_q;
  assign bus.oGESTURE  = gest_q;
  assign bus.oGEST_STB = gstb_q;

endmodule

// File: tb/tb_touch_event_filter.sv
// Directed bench for touch_event_filter with POLL_DIV=10, DEB_CNT=3,
// HOLD_SAMPLES=5. Expected sample results are queued when a sample is driven
// and checked when the registered outputs appear one cycle later.
module tb_touch_event_filter;
  import touch_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  touch_event_filter_if tif ();

  touch_event_filter #(
    .POLL_DIV     (10),
    .DEB_CNT      (3),
    .HOLD_SAMPLES (5)
  ) dut (
    .iCLK  (clk),
    .iRSTN (rstn),
    .bus   (tif)
  );

  typedef struct {
    logic          press;
    logic          tap;
    logic          lng;
    logic          rel;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   n_trig = 0, n_tap = 0, n_rel = 0, n_long = 0;

  always @(posedge clk) cyc++;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (tif.oTRIG)    n_trig++;
    if (tif.oTAP)     n_tap++;
    if (tif.oRELEASE) n_rel++;
    if (tif.oLONG)    n_long++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      step();
      if (tif.oTRIG === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic sample(input string tag, input logic [1:0] tc, input logic [XW-1:0] x,
                        input logic [YW-1:0] y, input logic [GW-1:0] g,
                        input logic e_press, input logic e_tap, input logic e_lng,
                        input logic e_rel, input logic [XW-1:0] ex, input logic [YW-1:0] ey);
    exp_t e;
    exp_q.push_back('{e_press, e_tap, e_lng, e_rel, ex, ey});
    tif.iREADY       = 1'b1;
    tif.iTOUCH_COUNT = tc;
    tif.iX1          = x;
    tif.iY1          = y;
    tif.iGESTURE     = g;
    step();
    tif.iREADY       = 1'b0;
    tif.iTOUCH_COUNT = 2'd0;
    tif.iGESTURE     = '0;
    e = exp_q.pop_front();
    chk({tag, ".press"}, 32'(tif.oPRESS), 32'(e.press));
    chk({tag, ".tap"},   32'(tif.oTAP),   32'(e.tap));
    chk({tag, ".long"},  32'(tif.oLONG),  32'(e.lng));
    chk({tag, ".rel"},   32'(tif.oRELEASE), 32'(e.rel));
    chk({tag, ".x"},     32'(tif.oX),     32'(e.x));
    chk({tag, ".y"},     32'(tif.oY),     32'(e.y));
  endtask

  logic [XW-1:0] cx [4];
  logic [YW-1:0] cy [4];

  initial begin
    int rel_cyc, t0, t1, nt0, nr0, nk0, nl0;

`ifdef TOUCH_AVG_EN
    cx[0] = 10'd100; cx[1] = 10'd101; cx[2] = 10'd103; cx[3] = 10'd106;
    cy[0] = 9'd50;   cy[1] = 9'd51;   cy[2] = 9'd53;   cy[3] = 9'd56;
`else
    cx[0] = 10'd100; cx[1] = 10'd104; cx[2] = 10'd108; cx[3] = 10'd112;
    cy[0] = 9'd50;   cy[1] = 9'd54;   cy[2] = 9'd58;   cy[3] = 9'd62;
`endif

    tif.iREADY       = 1'b0;
    tif.iX1          = '0;
    tif.iY1          = '0;
    tif.iTOUCH_COUNT = 2'd0;
    tif.iGESTURE     = '0;

    // Reset state
    rstn = 1'b0;
    step();
    step();
    chk("rst.trig",  32'(tif.oTRIG),  0);
    chk("rst.press", 32'(tif.oPRESS), 0);
    chk("rst.x",     32'(tif.oX),     0);
    chk("rst.y",     32'(tif.oY),     0);
    chk("rst.miss",  32'(tif.oMISS),  0);
    chk("rst.gest",  32'(tif.oGESTURE), 0);
    rstn    = 1'b1;
    rel_cyc = cyc;

    // Regular polling with ready 3 cycles after each request
    wait_trig(40, t0);
    chk("poll.first_lat", 32'(t0 - rel_cyc), 10);
    for (int i = 0; i < 4; i++) begin
      step();
      step();
      tif.iREADY = 1'b1;
      step();
      tif.iREADY = 1'b0;
      wait_trig(40, t1);
      chk("poll.period", 32'(t1 - t0), 10);
      t0 = t1;
    end
    chk("poll.miss0", 32'(tif.oMISS), 0);

    // Ready coincident with wrap: request still issued, no miss
    repeat (9) step();
    tif.iREADY = 1'b1;
    step();
    tif.iREADY = 1'b0;
    chk("coinc.trig", 32'(tif.oTRIG), 1);
    chk("coinc.period", 32'(cyc - t0), 10);
    chk("coinc.miss", 32'(tif.oMISS), 0);

    // Three wraps with no ready
    step();
    nt0 = n_trig;
    repeat (34) step();
    chk("miss.three", 32'(tif.oMISS), 3);
    chk("miss.no_trig", 32'(n_trig - nt0), 0);
    tif.iREADY = 1'b1;
    step();
    tif.iREADY = 1'b0;
    wait_trig(20, t1);
    chk("miss.trig_resumes", 32'(t1 > 0), 1);
    chk("miss.held", 32'(tif.oMISS), 3);
    repeat (3000) step();
    chk("miss.saturate", 32'(tif.oMISS), 255);

    // Fresh start for sample processing
    rstn = 1'b0;
    step();
    chk("rst2.miss", 32'(tif.oMISS), 0);
    rstn = 1'b1;
    step();

    // Debounce: T,T,U,T,T,T then 3 U -> tap
    sample("A1", 2'd1, 10'd300, 9'd150, 8'd0, 0, 0, 0, 0, 10'd300, 9'd150);
    sample("A2", 2'd2, 10'd300, 9'd150, 8'd0, 0, 0, 0, 0, 10'd300, 9'd150);
    sample("A3", 2'd0, 10'd999, 9'd500, 8'd0, 0, 0, 0, 0, 10'd300, 9'd150);
    sample("A4", 2'd3, 10'd300, 9'd150, 8'd0, 0, 0, 0, 0, 10'd300, 9'd150);
    sample("A5", 2'd1, 10'd300, 9'd150, 8'd0, 0, 0, 0, 0, 10'd300, 9'd150);
    sample("A6", 2'd1, 10'd300, 9'd150, 8'd0, 1, 0, 0, 0, 10'd300, 9'd150);
    sample("A7", 2'd0, 10'd999, 9'd500, 8'd0, 1, 0, 0, 0, 10'd300, 9'd150);
    sample("A8", 2'd0, 10'd999, 9'd500, 8'd0, 1, 0, 0, 0, 10'd300, 9'd150);
    sample("A9", 2'd0, 10'd999, 9'd500, 8'd0, 0, 1, 0, 1, 10'd300, 9'd150);
    step();
    chk("A.tap_one_cycle", 32'(tif.oTAP), 0);
    chk("A.rel_one_cycle", 32'(tif.oRELEASE), 0);

    // Long press: 8 T then 3 U -> one long, release, no tap
    nl0 = n_long;
    nk0 = n_tap;
    sample("B1", 2'd1, 10'd400, 9'd200, 8'd0, 0, 0, 0, 0, 10'd400, 9'd200);
    sample("B2", 2'd1, 10'd400, 9'd200, 8'd0, 0, 0, 0, 0, 10'd400, 9'd200);
    for (int i = 3; i <= 7; i++)
      sample($sformatf("B%0d", i), 2'd1, 10'd400, 9'd200, 8'd0, 1, 0, 0, 0, 10'd400, 9'd200);
    sample("B8", 2'd1, 10'd400, 9'd200, 8'd0, 1, 0, 1, 0, 10'd400, 9'd200);
    sample("B9", 2'd0, 10'd0, 9'd0, 8'd0, 1, 0, 0, 0, 10'd400, 9'd200);
    sample("B10", 2'd0, 10'd0, 9'd0, 8'd0, 1, 0, 0, 0, 10'd400, 9'd200);
    sample("B11", 2'd0, 10'd0, 9'd0, 8'd0, 0, 0, 0, 1, 10'd400, 9'd200);
    step();
    chk("B.long_count", 32'(n_long - nl0), 1);
    chk("B.tap_count", 32'(n_tap - nk0), 0);

    // Coordinate filtering, then gesture during release debounce
    sample("C1", 2'd1, 10'd100, 9'd50, 8'd0, 0, 0, 0, 0, cx[0], cy[0]);
    sample("C2", 2'd1, 10'd104, 9'd54, 8'd0, 0, 0, 0, 0, cx[1], cy[1]);
    sample("C3", 2'd1, 10'd108, 9'd58, 8'd0, 1, 0, 0, 0, cx[2], cy[2]);
    sample("C4", 2'd1, 10'd112, 9'd62, 8'd0, 1, 0, 0, 0, cx[3], cy[3]);
    sample("C5", 2'd0, 10'd7, 9'd7, 8'h5A, 1, 0, 0, 0, cx[3], cy[3]);
    chk("C5.gstb", 32'(tif.oGEST_STB), 1);
    chk("C5.gest", 32'(tif.oGESTURE), 32'h5A);
    sample("C6", 2'd0, 10'd7, 9'd7, 8'h00, 1, 0, 0, 0, cx[3], cy[3]);
    chk("C6.gstb", 32'(tif.oGEST_STB), 0);
    chk("C6.gest", 32'(tif.oGESTURE), 32'h5A);
    sample("C7", 2'd0, 10'd7, 9'd7, 8'h00, 0, 1, 0, 1, cx[3], cy[3]);

    // Reset while pressed: async clear, no events afterwards
    sample("D1", 2'd1, 10'd50, 9'd25, 8'd0, 0, 0, 0, 0, 10'd50, 9'd25);
    sample("D2", 2'd1, 10'd50, 9'd25, 8'd0, 0, 0, 0, 0, 10'd50, 9'd25);
    sample("D3", 2'd1, 10'd50, 9'd25, 8'h11, 1, 0, 0, 0, 10'd50, 9'd25);
    rstn = 1'b0;
    #1;
    chk("D.rst_press", 32'(tif.oPRESS), 0);
    chk("D.rst_x", 32'(tif.oX), 0);
    chk("D.rst_y", 32'(tif.oY), 0);
    chk("D.rst_gest", 32'(tif.oGESTURE), 0);
    chk("D.rst_gstb", 32'(tif.oGEST_STB), 0);
    step();
    nr0  = n_rel;
    nk0  = n_tap;
    rstn = 1'b1;
    rel_cyc = cyc;
    wait_trig(40, t0);
    chk("D.first_trig_lat", 32'(t0 - rel_cyc), 10);
    repeat (5) step();
    chk("D.no_release", 32'(n_rel - nr0), 0);
    chk("D.no_tap", 32'(n_tap - nk0), 0);
    chk("D.press_low", 32'(tif.oPRESS), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
